// File: rtl/difftest_deferred_pkg.sv
// Shared codes, widths and checker hooks for the deferred difftest controller.
// Checker hooks are an SV model that logs batches and replays verdicts.
package difftest_deferred_pkg;

  localparam logic [7:0] SIMV_NONE = 8'h00;
  localparam logic [7:0] SIMV_DONE = 8'h01;
  localparam logic [7:0] SIMV_FAIL = 8'h02;

  localparam int STEP_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  int unsigned nstep_log[$];
  byte         result_script[$];
  int unsigned result_calls;

  function automatic void difftest_deferred_nstep(
    input int unsigned n
  );
    nstep_log.push_back(n);
  endfunction

  function automatic byte difftest_deferred_result();
    result_calls++;
    if (result_script.size() == 0)
      return 8'h00;
    return result_script.pop_front();
  endfunction

endpackage

// File: rtl/difftest_deferred_ctrl_accumulator.sv
// Step accumulator: batches committed-step counts and pushes them
// to the checker on interval, threshold or forced flush.
module deferred_step_accumulator
  import difftest_deferred_pkg::*;
#(
  parameter int STEP_W         = STEP_W_DEF,
  parameter int ACC_W          = ACC_W_DEF,
  parameter int FLUSH_INTERVAL = 64
) (
  input logic              clock,
  input logic              reset,
  input logic [STEP_W-1:0] step,
  input logic              force_flush,
  input logic              halt
);

  localparam int CNT_W =
    (FLUSH_INTERVAL > 1) ? $clog2(FLUSH_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(FLUSH_INTERVAL - 1);
  localparam logic [ACC_W-1:0] FLUSH_THRESH =
    ACC_W'(1) << (ACC_W - 1);

  if (STEP_W >= ACC_W - 1) begin : g_bad_width
    $error("STEP_W must be smaller than ACC_W-1");
  end
  if (FLUSH_INTERVAL < 1) begin : g_bad_interval
    $error("FLUSH_INTERVAL must be at least 1");
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] flush_cnt;
  logic             flush;

  assign acc_next = acc + ACC_W'(step);

  // the threshold keeps acc below 2**(ACC_W-1), so acc_next cannot wrap
  assign flush = force_flush
              || (flush_cnt == CNT_LAST)
              || (acc_next >= FLUSH_THRESH);

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc       <= '0;
      flush_cnt <= '0;
    end else if (!halt) begin
      if (flush) begin
        if (acc_next != '0)
          difftest_deferred_nstep(32'(acc_next));
        acc       <= '0;
        flush_cnt <= '0;
      end else begin
        acc       <= acc_next;
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/difftest_deferred_ctrl.sv
// Deferred difftest controller: batched step push, periodic verdict poll.
// Define DIFFTEST_INTERNAL_STEP_EN when the checker steps itself.
module difftest_deferred_ctrl
  import difftest_deferred_pkg::*;
#(
  parameter int STEP_W         = STEP_W_DEF,
  parameter int ACC_W          = ACC_W_DEF,
  parameter int FLUSH_INTERVAL = 64,
  parameter int POLL_INTERVAL  = 256
) (
  input  logic              clock,
  input  logic              reset,
`ifndef DIFFTEST_INTERNAL_STEP_EN
  input  logic [STEP_W-1:0] step,
`endif
  output logic [7:0]        simv_result
);

  localparam int PCNT_W =
    (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST =
    PCNT_W'(POLL_INTERVAL - 1);

  if (POLL_INTERVAL < 1) begin : g_bad_poll
    $error("POLL_INTERVAL must be at least 1");
  end

  logic [PCNT_W-1:0] poll_cnt;
  logic              poll;
  logic              halt;

  assign poll = (poll_cnt == PCNT_W'(PCNT_LAST));
  assign halt = (simv_result != SIMV_NONE);

`ifndef DIFFTEST_INTERNAL_STEP_EN
  // a poll cycle also flushes, so the fetch covers every step so far
  deferred_step_accumulator #(
    .STEP_W         (STEP_W),
    .ACC_W          (ACC_W),
    .FLUSH_INTERVAL (FLUSH_INTERVAL)
  ) u_acc (
    .clock       (clock),
    .reset       (reset),
    .step        (step),
    .force_flush (poll),
    .halt        (halt)
  );
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      poll_cnt    <= '0;
      simv_result <= SIMV_NONE;
    end else if (!halt) begin
      if (poll) begin
        simv_result <= difftest_deferred_result();
        poll_cnt    <= '0;
      end else begin
        poll_cnt <= poll_cnt + PCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_difftest_deferred_ctrl.sv
// Directed bench for difftest_deferred_ctrl using the SV checker model.
module tb_difftest_deferred_ctrl;
  import difftest_deferred_pkg::*;

  logic       clock;
  logic       rst_a;
  logic       rst_b;
  logic [7:0] step_a;
  logic [7:0] step_b;
  logic [7:0] res_a;
  logic [7:0] res_b;

  int checks = 0;
  int errors = 0;

  difftest_deferred_ctrl #(
    .STEP_W(8), .ACC_W(10),
    .FLUSH_INTERVAL(64), .POLL_INTERVAL(256)
  ) dut_a (
    .clock(clock), .reset(rst_a),
    .step(step_a), .simv_result(res_a)
  );

  difftest_deferred_ctrl #(
    .STEP_W(8), .ACC_W(32),
    .FLUSH_INTERVAL(64), .POLL_INTERVAL(8)
  ) dut_b (
    .clock(clock), .reset(rst_b),
    .step(step_b), .simv_result(res_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] log_at(input int i);
    if (i < nstep_log.size())
      return 64'(nstep_log[i]);
    return '1;
  endfunction

  initial begin
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    step_a = 8'd3;
    step_b = 8'd3;

    repeat (5) begin
      tick();
      check("reset_res_a", 64'(res_a), 64'd0);
      check("reset_res_b", 64'(res_b), 64'd0);
    end
    check("reset_nstep_cnt", 64'(nstep_log.size()), 64'd0);
    check("reset_result_cnt", 64'(result_calls), 64'd0);

    rst_a  = 1'b1;
    step_a = 8'd1;
    repeat (63) tick();
    check("int1_before", 64'(nstep_log.size()), 64'd0);
    tick();
    check("int1_cnt", 64'(nstep_log.size()), 64'd1);
    check("int1_val", log_at(0), 64'd64);
    repeat (64) tick();
    check("int2_cnt", 64'(nstep_log.size()), 64'd2);
    check("int2_val", log_at(1), 64'd64);

    step_a = 8'd0;
    repeat (64) tick();
    check("zero_int_cnt", 64'(nstep_log.size()), 64'd2);

    step_a = 8'd1;
    repeat (40) tick();
    rst_a = 1'b0;
    tick();
    rst_a  = 1'b1;
    step_a = 8'd2;
    check("midrst_cnt", 64'(nstep_log.size()), 64'd2);
    check("midrst_res", 64'(res_a), 64'd0);
    repeat (63) tick();
    check("postrst_before", 64'(nstep_log.size()), 64'd2);
    tick();
    check("postrst_cnt", 64'(nstep_log.size()), 64'd3);
    check("postrst_val", log_at(2), 64'd128);
    check("postrst_res", 64'(res_a), 64'd0);

    rst_a = 1'b0;
    tick();
    rst_a  = 1'b1;
    step_a = 8'd255;
    tick();
    tick();
    check("thresh_before", 64'(nstep_log.size()), 64'd3);
    tick();
    check("thresh_cnt", 64'(nstep_log.size()), 64'd4);
    check("thresh_val", log_at(3), 64'd765);
    step_a = 8'd1;
    repeat (63) tick();
    check("thresh_after_before", 64'(nstep_log.size()), 64'd4);
    tick();
    check("thresh_after_cnt", 64'(nstep_log.size()), 64'd5);
    check("thresh_after_val", log_at(4), 64'd64);
    rst_a = 1'b0;
    check("a_no_polls", 64'(result_calls), 64'd0);

    result_script.push_back(8'h00);
    result_script.push_back(8'h02);
    rst_b  = 1'b1;
    step_b = 8'd1;
    repeat (7) tick();
    check("poll1_before_cnt", 64'(nstep_log.size()), 64'd5);
    check("poll1_before_calls", 64'(result_calls), 64'd0);
    tick();
    check("poll1_nstep_cnt", 64'(nstep_log.size()), 64'd6);
    check("poll1_nstep_val", log_at(5), 64'd8);
    check("poll1_calls", 64'(result_calls), 64'd1);
    check("poll1_res", 64'(res_b), 64'd0);
    repeat (7) tick();
    check("poll2_before_res", 64'(res_b), 64'd0);
    tick();
    check("poll2_nstep_cnt", 64'(nstep_log.size()), 64'd7);
    check("poll2_nstep_val", log_at(6), 64'd8);
    check("poll2_calls", 64'(result_calls), 64'd2);
    check("poll2_res", 64'(res_b), 64'd2);

    step_b = 8'd7;
    repeat (100) begin
      tick();
      check("sticky_res", 64'(res_b), 64'd2);
    end
    check("sticky_nstep_cnt", 64'(nstep_log.size()), 64'd7);
    check("sticky_calls", 64'(result_calls), 64'd2);

    rst_b = 1'b0;
    tick();
    check("sticky_cleared", 64'(res_b), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
